// File: rtl/tns_dec_seq.sv
// tns_dec_seq: multi-cycle TNS codeword decoder that sums the weights of the set bits.
// It handles one 3-bit group per clock and uses valid/ready handshakes on the input and the output.
package tns_dec_seq_pkg;
    function automatic longint unsigned weight(input int i);
        longint unsigned a = 1, b = 2, c = 4, n;
        if (i < 3) return 64'd1 << i;
        for (int k = 3; k <= i; k++) begin
            n = a + b + c;
            a = b;
            b = c;
            c = n;
        end
        return c;
    endfunction
    function automatic longint unsigned wsum(input int n);
        longint unsigned s = 0;
        for (int i = 0; i < n; i++) s += weight(i);
        return s;
    endfunction
endpackage

module tns_dec_seq #(
    parameter int GROUPS = 3,
    localparam int CW = 3 * GROUPS,
    localparam int DW = $clog2(tns_dec_seq_pkg::wsum(CW) + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] codein,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          busy
);
    localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] code_q, code_d;
    logic [DW-1:0] acc_q, acc_d, dout_q, dout_d, grp_add;
    logic [GW-1:0] grp_q, grp_d;
    logic [DW-1:0] wts [CW];
    for (genvar i = 0; i < CW; i++) begin : g_w
        assign wts[i] = DW'(tns_dec_seq_pkg::weight(i));
    end
    // Constant weight mux: only the group selected by grp contributes this cycle.
    always_comb begin
        grp_add = '0;
        for (int k = 0; k < GROUPS; k++)
            if (grp_q == GW'(k))
                grp_add = (code_q[3*k] ? wts[3*k] : '0) + (code_q[3*k+1] ? wts[3*k+1] : '0) + (code_q[3*k+2] ? wts[3*k+2] : '0);
    end
    assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
    assign out_valid = state_q == DONE;
    assign busy      = state_q == ACC;
    assign dataout   = dout_q;
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        acc_d   = acc_q;
        grp_d   = grp_q;
        dout_d  = dout_q;
        if (state_q == ACC) begin
            acc_d = acc_q + grp_add;
            grp_d = grp_q + GW'(1);
            if (grp_q == GW'(GROUPS - 1)) begin
                dout_d  = acc_d;
                state_d = DONE;
            end
        end else if (in_valid && in_ready) begin
            state_d = ACC;
            code_d  = codein;
            acc_d   = '0;
            grp_d   = '0;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            acc_q   <= '0;
            grp_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            acc_q   <= acc_d;
            grp_q   <= grp_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: doc/tns_dec_seq.md
# tns_dec_seq

Parametrised, multi-cycle decoder for the TNS crosstalk-avoidance codeword format. It converts a codeword of GROUPS 3-bit groups into its binary value by summing the weights of the set bits, one group per clock. Valid/ready handshakes on the input and output let it sit between the link receiver and the binary datapath. It generalises the fixed 9-bit combinational TNS decoder to any group count, and adds flow control and an output hold register.

## Interface
- GROUPS, default 3: number of 3-bit codeword groups; legal range 1..10.
- CW, default 3*GROUPS (localparam): codeword width.
- DW, default clog2(WSUM+1) (localparam): output width. WSUM is the sum of all CW weights; DW = 9 for GROUPS=3.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  codein is valid.
- in_ready  out  1  block accepts codein this cycle.
- codein  in  CW  codeword; bit i has weight w[i].
- out_valid  out  1  dataout holds a finished result.
- out_ready  in  1  downstream consumes dataout.
- dataout  out  DW  decoded binary value.
- busy  out  1  high in ACC.

## Operation
- Weight sequence, fixed at elaboration:
  - w[0]=1, w[1]=2, w[2]=4.
  - w[i]=w[i-1]+w[i-2]+w[i-3] for i≥3.
  - For GROUPS=3 the weights are 1,2,4,7,13,24,44,81,149, so WSUM=325.
- Group k is codein[3k+2:3k]; bit 3k+j carries weight w[3k+j].
- Result = Σ codein[i]·w[i], exact and unsigned. DW is sized so the sum never overflows; no saturation or wrap is needed.
- States: IDLE, ACC, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid, latch codein into code_r, clear the accumulator, set grp=0, go to ACC.
  - ACC:
    - in_ready=0, busy=1.
    - Each cycle: acc ← acc + group-grp contribution (three weighted bits of code_r), then grp ← grp+1.
    - After group GROUPS-1 is added, load dataout ← final acc and go to DONE.
  - DONE:
    - out_valid=1; dataout is held stable.
    - in_ready = out_ready.
    - out_ready=1 and in_valid=1: accept the new codeword; go to ACC (back-to-back).
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=0: stay in DONE; ignore in_valid.
- Reset values: state IDLE; in_ready=1; out_valid=0; busy=0; dataout=0; accumulator, grp and code_r = 0.
- rst is asserted mid-operation, in ACC or DONE: the in-flight word is discarded with no output. On the next cycle the block is in IDLE with the reset values above.
- in_valid while in ACC: not accepted, because in_ready=0. The upstream block holds codein and in_valid.
- codein is sampled only on the accept cycle. Later changes to codein do not affect the result.
- Any codein pattern is decoded arithmetically, including patterns outside the legal code set. There is no error flag.

## Timing
- Accept at rising edge T. ACC spans edges T+1 … T+GROUPS. out_valid rises after edge T+GROUPS.
  - Latency = GROUPS cycles from accept to out_valid; 3 for the default.
- Output handshake completes on the edge where out_valid && out_ready.
- Back-to-back throughput: one word per GROUPS+1 cycles (GROUPS in ACC, 1 in DONE).
- dataout, out_valid, in_ready and busy are all registered state or decodes of state. The only exception is in_ready in DONE, which follows out_ready combinationally.
- Critical path: one 3-term weighted add into a DW-bit accumulator. The weight per group is a constant mux indexed by grp.

## Test plan
- Reset and single words (GROUPS=3):
  - After reset: in_ready=1, out_valid=0, dataout=0.
  - codein 9'b000000001 → dataout=1.
  - codein 9'b100000000 → dataout=149.
  - In each case out_valid rises exactly 3 cycles after accept.
- Full and patterned words:
  - 9'b111111111 → 325.
  - 9'b010101010 → 114.
  - 9'b000000111 → 7.
  - 9'b000000000 → 0.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: dataout is stable, out_valid stays 1, no new word is accepted.
  - When out_ready=1, the queued word is accepted in that same cycle and its result follows 3 cycles later.
- Streaming: out_ready=1 and a continuous random in_valid stream.
  - Required: one result every 4 cycles.
  - Every result matches a Σ-weight reference model.
- Reset mid-operation: assert rst in the second ACC cycle.
  - Required: no out_valid for that word; IDLE on the next cycle.
  - The next word decodes correctly.
- Parameter sweep: GROUPS=1, 4 and 10, with random codewords.
  - Required: exact match to the reference model.
  - Latency equals GROUPS.
  - dataout does not overflow at all-ones (WSUM).
